// File: rtl/mlp_seq_engine_if.sv
// Handshake and data bundle between a vector source/sink and mlp_seq_engine.
// The master side drives inputs, weights and out_ready; the engine is the slave.
interface mlp_seq_engine_if #(
  parameter int DW    = 5,
  parameter int N_IN  = 4,
  parameter int N_HID = 4,
  parameter int N_OUT = 2,
  parameter int OW    = 2*DW + $clog2(N_IN) + DW + $clog2(N_HID)
);
  logic                      in_valid;
  logic                      in_ready;
  logic [N_IN*DW-1:0]        x;
  logic                      relu_en;
  logic [N_IN*N_HID*DW-1:0]  w1;
  logic [N_HID*N_OUT*DW-1:0] w2;
  logic                      out_valid;
  logic                      out_ready;
  logic [N_OUT*OW-1:0]       y;

  modport master (
    output in_valid, x, relu_en, w1, w2, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, x, relu_en, w1, w2, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/mlp_seq_engine.sv
// Time-multiplexed two-layer perceptron: one signed MAC walks every neuron of
// the hidden layer (optional ReLU) and then the output layer.
module mlp_seq_engine #(
  parameter int DW    = 5,
  parameter int N_IN  = 4,
  parameter int N_HID = 4,
  parameter int N_OUT = 2,
  parameter int HW    = 2*DW + $clog2(N_IN),
  parameter int OW    = HW + DW + $clog2(N_HID)
) (
  input  logic            clk,
  input  logic            rst_n,
  mlp_seq_engine_if.slave bus
);
  localparam int IW  = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int HCW = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int OCW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;
  state_t state_q, state_d;

  logic signed [DW-1:0] x_in   [N_IN];
  logic signed [DW-1:0] w1_arr [N_IN][N_HID];
  logic signed [DW-1:0] w2_arr [N_HID][N_OUT];

  logic signed [DW-1:0] x_q   [N_IN];
  logic signed [DW-1:0] x_d   [N_IN];
  logic signed [HW-1:0] hid_q [N_HID];
  logic signed [HW-1:0] hid_d [N_HID];
  logic signed [OW-1:0] y_q   [N_OUT];
  logic signed [OW-1:0] y_d   [N_OUT];
  logic signed [OW-1:0] acc_q, acc_d;
  logic [IW-1:0]        i_q, i_d;
  logic [HCW-1:0]       h_q, h_d;
  logic [OCW-1:0]       o_q, o_d;
  logic                 relu_q, relu_d;
  logic                 out_valid_q, out_valid_d;

  logic signed [OW-1:0] mac_a, mac_b, prod, sum;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_in
    assign x_in[gi] = bus.x[gi*DW +: DW];
    for (genvar gh = 0; gh < N_HID; gh++) begin : g_w1
      assign w1_arr[gi][gh] = bus.w1[(gi*N_HID+gh)*DW +: DW];
    end
  end

  for (genvar gi = 0; gi < N_HID; gi++) begin : g_hid
    for (genvar go = 0; go < N_OUT; go++) begin : g_w2
      assign w2_arr[gi][go] = bus.w2[(gi*N_OUT+go)*DW +: DW];
    end
  end

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_y
    assign bus.y[gi*OW +: OW] = y_q[gi];
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;

  function automatic logic signed [OW-1:0] sext_dw(input logic signed [DW-1:0] v);
    return {{(OW-DW){v[DW-1]}}, v};
  endfunction

  function automatic logic signed [OW-1:0] sext_hw(input logic signed [HW-1:0] v);
    return {{(OW-HW){v[HW-1]}}, v};
  endfunction

  // Shared multiplier: operands come from the layer currently being walked.
  always_comb begin
    mac_a = sext_hw(hid_q[h_q]);
    mac_b = sext_dw(w2_arr[h_q][o_q]);
    if (state_q == L1) begin
      mac_a = sext_dw(x_q[i_q]);
      mac_b = sext_dw(w1_arr[i_q][h_q]);
    end
  end

  assign prod = mac_a * mac_b;
  assign sum  = acc_q + prod;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    relu_d      = relu_q;
    hid_d       = hid_q;
    y_d         = y_q;
    acc_d       = acc_q;
    i_d         = i_q;
    h_d         = h_q;
    o_d         = o_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d     = x_in;
          relu_d  = bus.relu_en;
          acc_d   = '0;
          i_d     = '0;
          h_d     = '0;
          state_d = L1;
        end
      end
      L1: begin
        acc_d = sum;
        i_d   = i_q + IW'(1);
        if (i_q == IW'(N_IN-1)) begin
          hid_d[h_q] = (relu_q && sum[OW-1]) ? '0 : sum[HW-1:0];
          acc_d      = '0;
          i_d        = '0;
          h_d        = h_q + HCW'(1);
          if (h_q == HCW'(N_HID-1)) begin
            h_d     = '0;
            o_d     = '0;
            state_d = L2;
          end
        end
      end
      L2: begin
        acc_d = sum;
        h_d   = h_q + HCW'(1);
        if (h_q == HCW'(N_HID-1)) begin
          y_d[o_q] = sum;
          acc_d    = '0;
          h_d      = '0;
          o_d      = o_q + OCW'(1);
          if (o_q == OCW'(N_OUT-1)) begin
            o_d         = '0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '{default: '0};
      hid_q       <= '{default: '0};
      y_q         <= '{default: '0};
      relu_q      <= 1'b0;
      acc_q       <= '0;
      i_q         <= '0;
      h_q         <= '0;
      o_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      hid_q       <= hid_d;
      y_q         <= y_d;
      relu_q      <= relu_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      h_q         <= h_d;
      o_q         <= o_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule
